// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART frame constants and FSM state type
package uart_tx_pkg;

    localparam int   DATA_BITS            = 8;
    localparam logic START_LEVEL          = 1'b0;
    localparam logic STOP_LEVEL           = 1'b1;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 10416;

    // Frame phases, common to the transmitter and the receiver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with combinational head read
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is dropped even when a pop frees a slot on the same edge
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_t r_state;
    uart_state_t w_state_next;

    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic             r_tx;
    logic             w_tx_next;

    logic             w_push;
    logic             w_pop;
    logic             w_bit_done;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [7:0]       w_fifo_dout;

    assign w_push     = tx_valid && !w_fifo_full;
    assign w_bit_done = (r_bit_cnt == LAST_CNT);

    assign tx_ready = !w_fifo_full;
    assign tx       = r_tx;
    assign busy     = (r_state != ST_IDLE);

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (tx_data),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (fifo_count)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: each phase advances when its bit period expires
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_fifo_empty) w_state_next = ST_START;
            ST_START: if (w_bit_done) w_state_next = ST_DATA;
            ST_DATA:  if (w_bit_done && (r_bit_idx == LAST_IDX)) w_state_next = ST_STOP;
            ST_STOP:  if (w_bit_done) w_state_next = w_fifo_empty ? ST_IDLE : ST_START;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: pop strobe and next values of counter, index, shifter and line
    always_comb begin
        w_pop          = 1'b0;
        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_tx_next      = r_tx;
        case (r_state)
            ST_IDLE: begin
                w_bit_cnt_next = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_tx_next    = START_LEVEL;
                end else begin
                    w_tx_next    = IDLE_LEVEL;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_bit_cnt_next = '0;
                    w_bit_idx_next = '0;
                    w_tx_next      = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_bit_cnt_next = '0;
                    if (r_bit_idx == LAST_IDX) begin
                        w_tx_next      = STOP_LEVEL;
                    end else begin
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_tx_next      = r_shift[1];
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_bit_cnt_next = '0;
                    // Chain straight into the next start bit when a byte is waiting
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_tx_next    = START_LEVEL;
                    end else begin
                        w_tx_next    = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                w_bit_cnt_next = '0;
                w_tx_next      = IDLE_LEVEL;
            end
        endcase
    end

    // Datapath registers; the line is forced idle-high asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= IDLE_LEVEL;
        end else begin
            r_bit_cnt <= w_bit_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks;
    int errors;

    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level of frame bit k (start, d0..d7, stop) for byte b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (!tx_ready) begin
            errors++;
            $display("FAIL push_timeout: tx_ready=%b required 1", tx_ready);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int guard;
        guard = 0;
        while (tx !== 1'b0 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL %s start_timeout: tx=%b required 0", name, tx);
        end
    endtask

    // Called at the first cycle of a start bit; returns one cycle after the stop bit ends
    task automatic check_frame(input logic [7:0] b, input string name);
        logic expv;
        for (int k = 0; k < 10; k++) begin
            expv = frame_bit(b, k);
            for (int c = 0; c < CPB; c++) begin
                if (c == 0 || c == CPB/2 || c == CPB-1) begin
                    checks++;
                    if (tx !== expv) begin
                        errors++;
                        $display("FAIL %s byte %02h bit %0d cyc %0d: tx=%b required %b",
                                 name, b, k, c, tx, expv);
                    end
                end
                if (c == CPB/2) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy bit %0d: busy=%b required 1", name, k, busy);
                    end
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL %s idle: tx=%b busy=%b count=%0d required 1 0 0",
                     name, tx, busy, fifo_count);
        end
    endtask

    // Pushes stim_q as fast as accepted while checking contiguous frames
    task automatic run_stream(input string name);
        fork
            begin
                for (int i = 0; i < stim_q.size(); i++) push_byte(stim_q[i]);
            end
            begin
                wait_start(name);
                for (int i = 0; i < stim_q.size(); i++) check_frame(stim_q[i], name);
                check_idle(name);
            end
        join
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #12;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b count=%0d required 1 0 0",
                     tx, busy, fifo_count);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: tx_ready=%b required 1", tx_ready);
        end
        check_idle("reset");
    endtask

    task automatic test_single(input logic [7:0] b, input string name);
        push_byte(b);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL %s accept_edge: tx=%b busy=%b count=%0d required 1 0 1",
                     name, tx, busy, fifo_count);
        end
        @(posedge clk); #1;
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL %s latency: tx=%b busy=%b count=%0d required 0 1 0",
                     name, tx, busy, fifo_count);
        end
        check_frame(b, name);
        check_idle(name);
    endtask

    task automatic test_back_to_back();
        stim_q = '{8'hA3, 8'h00, 8'hFF};
        run_stream("b2b");
    endtask

    task automatic test_random_stream();
        stim_q.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
        run_stream("rand_stream");
    endtask

    task automatic test_full_fifo();
        int accepted;
        logic [7:0] b;
        accepted = 0;
        exp_q.delete();
        fork
            begin
                tx_valid = 1'b1;
                for (int i = 0; i < 40; i++) begin
                    tx_data = 8'($urandom);
                    if (tx_ready) begin
                        exp_q.push_back(tx_data);
                        accepted++;
                    end
                    @(posedge clk); #1;
                end
                tx_valid = 1'b0;
                checks++;
                if (accepted != 5 || fifo_count !== 3'd4 || tx_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_accept: accepted=%0d count=%0d ready=%b required 5 4 0",
                             accepted, fifo_count, tx_ready);
                end
            end
            begin
                wait_start("full");
                for (int i = 0; i < 5; i++) begin
                    b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    check_frame(b, "full");
                    if (i == 0) begin
                        checks++;
                        if (fifo_count !== 3'd3 || tx_ready !== 1'b1) begin
                            errors++;
                            $display("FAIL full_release: count=%0d ready=%b required 3 1",
                                     fifo_count, tx_ready);
                        end
                    end
                end
                check_idle("full");
            end
        join
    endtask

    task automatic test_push_on_pop();
        logic [7:0] b0, b1, b2;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        fork
            begin
                push_byte(b0);
                push_byte(b1);
                repeat (10*CPB - 1) @(posedge clk);
                #1;
                checks++;
                if (fifo_count !== 3'd1) begin
                    errors++;
                    $display("FAIL pop_push_before: count=%0d required 1", fifo_count);
                end
                tx_data  = b2;
                tx_valid = 1'b1;
                @(posedge clk); #1;
                tx_valid = 1'b0;
                checks++;
                if (fifo_count !== 3'd1) begin
                    errors++;
                    $display("FAIL pop_push_after: count=%0d required 1", fifo_count);
                end
            end
            begin
                wait_start("pop_push");
                check_frame(b0, "pop_push");
                check_frame(b1, "pop_push");
                check_frame(b2, "pop_push");
                check_idle("pop_push");
            end
        join
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'($urandom) & 8'hF7;
        push_byte(b);
        push_byte(8'($urandom));
        wait_start("rst_mid");
        repeat (4*CPB + CPB/2) @(posedge clk);
        #3;
        checks++;
        if (tx !== 1'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL rst_mid_pre: tx=%b count=%0d required 0 1", tx, fifo_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_async: tx=%b busy=%b count=%0d required 1 0 0",
                     tx, busy, fifo_count);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst_mid_release");
        test_single(8'($urandom), "rst_mid_next");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single(8'h55, "single_55");
        test_single(8'($urandom), "single_rand");
        test_back_to_back();
        test_full_fifo();
        test_push_on_pop();
        test_random_stream();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter, the transmit-side counterpart to the design's UART receiver. Accepts bytes over a valid/ready handshake into a small FIFO and serialises them on `tx` as 8N1 frames, LSB first, at a fixed bit period set in clock cycles. Frames from queued bytes are sent back-to-back with no idle gap. Its `tx` output drives the `rx` line of a peer UART or a loopback into the existing receiver.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10416: clock cycles per serial bit. Must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte-buffer depth. Must be a power of two, ≥ 2.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `tx_data`, input, 8: byte to send.
- `tx_valid`, input, 1: `tx_data` is valid.
- `tx_ready`, output, 1: FIFO can accept a byte. Equal to `!full`.
- `tx`, output, 1: serial line. Registered; idles high.
- `busy`, output, 1: a frame is in progress (state ≠ IDLE).
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: bytes queued, not counting the byte being shifted.

## Operation
- Push: `tx_valid && tx_ready` at a rising edge writes `tx_data` into the FIFO.
  - When full, `tx_ready` is 0 and input is ignored, even if a pop happens on the same edge.
- FSM states: IDLE, START, DATA, STOP.
  - Bit counter: 0..CLKS_PER_BIT-1.
  - Bit index: 0..7.
- IDLE, FIFO non-empty: pop the head into the shift register, `tx` ← 0, go to START, clear the bit counter.
- START: after CLKS_PER_BIT cycles, `tx` ← `shift[0]`, go to DATA, bit index ← 0.
- DATA: every CLKS_PER_BIT cycles, shift right and increment the bit index.
  - After bit 7 has been held for its full period, `tx` ← 1 and go to STOP.
- STOP: after CLKS_PER_BIT cycles:
  - If the FIFO is non-empty, pop the next byte, `tx` ← 0, go directly to START.
  - Otherwise `tx` ← 1, go to IDLE.
- Simultaneous push and pop on a non-full FIFO:
  - Both take effect.
  - `fifo_count` is unchanged.
  - A push to an empty FIFO while the FSM is IDLE is popped on the following edge, never on the same edge.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are derived from `fifo_count`.
- `tx_data` changes while not handshaken have no effect.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - `tx` = 1, state = IDLE, `busy` = 0.
  - `fifo_count` = 0, pointers = 0.
  - `tx_ready` = 1 once `rst_n` is high.
- Latency, accepting edge N with FSM IDLE and FIFO empty:
  - Edge N+1: pop happens, `tx` falls, `busy` rises.
- Frame: exactly 10×CLKS_PER_BIT cycles.
  - Start bit, then d0..d7, then stop bit.
  - Each level is held for exactly CLKS_PER_BIT cycles.
- Back-to-back: the next start bit begins on the edge that ends the previous stop bit, with zero extra idle cycles.
- `busy` falls on the same edge that `tx` returns to idle high after the last stop bit.
- Reset mid-frame: `tx` goes high immediately (asynchronous). The FIFO contents and the partial frame are discarded.

## Structure
- Shared UART package holds:
  - Frame constants: DATA_BITS = 8, START_LEVEL = 0, STOP_LEVEL = 1, IDLE_LEVEL = 1.
  - The FSM state enum (IDLE/START/DATA/STOP), shared with the receiver.
  - The default CLKS_PER_BIT = 10416.
- Sub-module `uart_sync_fifo`:
  - Parameters: width, depth.
  - Ports: push, pop, din, dout (head, combinational read), full, empty, count.
  - It is reusable for the receiver's output buffer.
- The top level holds only the FSM, the bit counter and the shift register.

## Test plan
- Reset, then single byte 0x55 with CLKS_PER_BIT=16 → `tx` samples taken mid-bit read 0,1,0,1,0,1,0,1,0,1. Each level lasts 16 cycles. `tx` falls exactly 1 cycle after the handshake edge.
- Queue 0xA3, 0x00, 0xFF back-to-back with CLKS_PER_BIT=16 → 480 contiguous cycles of frames with no idle gap. Decoded bytes are 0xA3, 0x00, 0xFF. `busy` stays high throughout.
- Hold `tx_valid` high with FIFO_DEPTH=4 during a frame → 5 bytes accepted in total (1 in the shifter, 4 queued). `tx_ready` drops when `fifo_count`=4 and rises again on the next pop.
- Push on the same edge as a STOP→START pop → `fifo_count` is unchanged. Byte order is preserved.
- Assert `rst_n`=0 during bit d3 → `tx`=1, `busy`=0 and `fifo_count`=0 without waiting for a clock edge. The next byte after release transmits correctly.
- Loopback of `tx` into the existing UART `rx` with the default CLKS_PER_BIT=10416, sending 0x4D → the receiver outputs 0x4D.
